ps2_key_decoder: RTL
====================

# ps2_key_decoder

Converts the raw byte stream from the PS/2 receiver (8-bit code plus ready level) into complete key events for scan code set 2. It strips `E0` (extended) and `F0` (break) prefixes and discards keyboard status bytes. Finished events are buffered in a small show-ahead FIFO with a valid/pop handshake. It sits directly downstream of the PS/2 receiver and feeds display or control logic.

## Interface
- `FIFO_DEPTH`, default 8: event FIFO depth; must be a power of two, ≥2.
- `Clock_50` input 1: system clock; all logic on the rising edge.
- `Resetn` input 1: asynchronous, active-low reset.
- `PS2_code` input 8: last assembled byte from the receiver; stable while `PS2_code_ready` is high.
- `PS2_code_ready` input 1: level signal. It rises one cycle after a new byte is valid, stays high until the next start bit, then drops.
- `event_data` output 10: head event `{extended, break, scancode[7:0]}`.
- `event_valid` output 1: FIFO non-empty.
- `event_pop` input 1: consume the head event; ignored when `event_valid` is 0.
- `event_count` output $clog2(FIFO_DEPTH)+1: number of stored events.
- `overflow` output 1: sticky; set when an event is dropped because the FIFO is full.
- `clear_overflow` input 1: synchronous clear of `overflow`.

## Operation
- New-byte detection: `code_rise = PS2_code_ready & ~ready_d`, where `ready_d` is a register of `PS2_code_ready`. Each byte is processed exactly once per rise, regardless of how long the level stays high.
- Prefix FSM (`S_IDLE`, `S_EXT`, `S_BRK`, `S_EXT_BRK`), advancing only on `code_rise`:
  - `S_IDLE`:
    - `E0` → `S_EXT`.
    - `F0` → `S_BRK`.
    - Status bytes `00, AA, EE, FA, FC, FF` are dropped; stay in `S_IDLE`.
    - Any other byte pushes `{0,0,code}`; stay in `S_IDLE`.
  - `S_EXT`:
    - `F0` → `S_EXT_BRK`.
    - `E0` → stay in `S_EXT`.
    - Any other byte pushes `{1,0,code}`, then → `S_IDLE`.
  - `S_BRK`:
    - `F0` → stay in `S_BRK`.
    - `E0` → `S_EXT_BRK`. This is tolerated ordering.
    - Any other byte pushes `{0,1,code}`, then → `S_IDLE`.
  - `S_EXT_BRK`:
    - `E0` or `F0` → stay in `S_EXT_BRK`.
    - Any other byte pushes `{1,1,code}`, then → `S_IDLE`.
- Status bytes are filtered only in `S_IDLE`. In the other states they are ordinary scancodes.
- FIFO: circular buffer with `$clog2(FIFO_DEPTH)`-bit read/write pointers that wrap naturally.
  - `event_count` is a separate counter, 0..FIFO_DEPTH.
  - `event_data` always shows the entry at the read pointer (show-ahead). It is don't-care when empty; the bench must not check it then.
- Push and pop rules:
  - Push while full without a pop: the event is dropped, `overflow` is set, and pointers and count are unchanged.
  - Push and pop in the same cycle while full: both are accepted and the count stays at FIFO_DEPTH.
  - Push and pop in the same cycle while empty: push only; the pop is ignored.
  - Push and pop in the same cycle otherwise: both happen and the count is unchanged.
- `overflow`: a drop event in the same cycle as `clear_overflow` leaves `overflow` = 1 (set wins).

## Timing
- Reset values:
  - FSM `S_IDLE`; `ready_d` = 0; pointers = 0.
  - `event_count` = 0, `event_valid` = 0, `overflow` = 0.
  - `event_data` = 10'd0 (the storage array is not reset).
- Latency: `code_rise` is combinational on cycle N. The event is written at the end of cycle N. `event_valid` and `event_data` show it in cycle N+1.
- Pop: with `event_pop` high in cycle N, the next head appears (or `event_valid` drops) in cycle N+1.
- If `PS2_code_ready` is high when `Resetn` is released, `ready_d` = 0 produces one `code_rise`, so the stale byte is processed once. This is accepted behaviour.
- Reset mid-sequence (for example after `E0`) discards the prefix state. The next byte is decoded from `S_IDLE`.
- Bytes arrive roughly every 1.1 ms. Throughput is never limited by the block, only by the consumer.

## Structure
- Shared package `ps2_pkg`:
  - FSM enum `ps2_dec_state_t`.
  - Constants `PS2_PREFIX_EXT = 8'hE0` and `PS2_PREFIX_BRK = 8'hF0`.
  - Status-byte constants.
  - Event struct `ps2_event_t {extended, brk, code}`, 10 bits.
- Natural sub-module `ps2_event_fifo`, parameterized by depth and width. It contains the pointer, count and full/empty logic. The top level holds the edge detect, FSM and overflow flag.

## Test plan
- Bytes `1C` → then `F0, 1C` (one rise each): two events `{0,0,1C}` then `{0,1,1C}`. `event_valid` rises 1 cycle after the first rise.
- `E0, 75` then `E0, F0, 75`: events `{1,0,75}` and `{1,1,75}`. No events are pushed for prefixes.
- `PS2_code_ready` held high for 1000 cycles with `1C`: exactly one event is pushed.
- `AA` and `FA` in `S_IDLE`: no events. `F0, AA`: event `{0,1,AA}`.
- Nine make codes with no pops (depth 8):
  - `event_count` = 8, `overflow` = 1, the ninth code is lost.
  - Pop once together with a tenth push: count stays 8, the head becomes the 2nd code.
  - `clear_overflow` then drops `overflow` to 0.
- `E0` received, then `Resetn` pulsed low mid-stream, then `1C`: single event `{0,0,1C}`. All outputs read their reset values during reset.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code-set-2 key decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } ps2_dec_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam logic [7:0] PS2_STAT_ERR0  = 8'h00;
    localparam logic [7:0] PS2_STAT_BAT   = 8'hAA;
    localparam logic [7:0] PS2_STAT_ECHO  = 8'hEE;
    localparam logic [7:0] PS2_STAT_ACK   = 8'hFA;
    localparam logic [7:0] PS2_STAT_BATF  = 8'hFC;
    localparam logic [7:0] PS2_STAT_ERR1  = 8'hFF;

    typedef struct packed {
        logic       extended;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    function automatic logic is_status(input logic [7:0] code);
        return (code == PS2_STAT_ERR0) || (code == PS2_STAT_BAT)  ||
               (code == PS2_STAT_ECHO) || (code == PS2_STAT_ACK)  ||
               (code == PS2_STAT_BATF) || (code == PS2_STAT_ERR1);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead circular FIFO with occupancy counter; reports pushes dropped when full.
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             empty;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // a pop on a full FIFO frees the slot the simultaneous push needs
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & full & ~pop_ok;

    assign valid = ~empty;
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 set-2 bytes into {extended, break, code} key events buffered in a FIFO.
//
//  state     | meaning
//  S_IDLE    | no prefix seen; status bytes filtered here
//  S_EXT     | E0 seen
//  S_BRK     | F0 seen
//  S_EXT_BRK | both E0 and F0 seen, in either order
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        Clock_50,
    input  logic                        Resetn,
    input  logic [7:0]                  PS2_code,
    input  logic                        PS2_code_ready,
    output logic [9:0]                  event_data,
    output logic                        event_valid,
    input  logic                        event_pop,
    output logic [$clog2(FIFO_DEPTH):0] event_count,
    output logic                        overflow,
    input  logic                        clear_overflow
);
    ps2_dec_state_t state, state_nxt;
    logic           ready_d;
    logic           code_rise;
    logic           push;
    ps2_event_t     evt;
    logic           drop;

    assign code_rise = PS2_code_ready & ~ready_d;

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state    <= S_IDLE;
            ready_d  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_d <= PS2_code_ready;
            if (drop)                overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
        end
    end

    always_comb begin
        state_nxt    = state;
        push         = 1'b0;
        evt.extended = 1'b0;
        evt.brk      = 1'b0;
        evt.code     = PS2_code;
        if (code_rise) begin
            case (state)
                S_IDLE: begin
                    if (PS2_code == PS2_PREFIX_EXT)      state_nxt = S_EXT;
                    else if (PS2_code == PS2_PREFIX_BRK) state_nxt = S_BRK;
                    else if (!is_status(PS2_code))       push      = 1'b1;
                end
                S_EXT: begin
                    if (PS2_code == PS2_PREFIX_BRK) state_nxt = S_EXT_BRK;
                    else if (PS2_code != PS2_PREFIX_EXT) begin
                        push         = 1'b1;
                        evt.extended = 1'b1;
                        state_nxt    = S_IDLE;
                    end
                end
                S_BRK: begin
                    if (PS2_code == PS2_PREFIX_EXT) state_nxt = S_EXT_BRK;
                    else if (PS2_code != PS2_PREFIX_BRK) begin
                        push      = 1'b1;
                        evt.brk   = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                S_EXT_BRK: begin
                    if (PS2_code != PS2_PREFIX_EXT && PS2_code != PS2_PREFIX_BRK) begin
                        push         = 1'b1;
                        evt.extended = 1'b1;
                        evt.brk      = 1'b1;
                        state_nxt    = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(ps2_event_t))
    ) u_fifo (
        .clk   (Clock_50),
        .rst_n (Resetn),
        .push  (push),
        .wdata (evt),
        .pop   (event_pop),
        .rdata (event_data),
        .valid (event_valid),
        .count (event_count),
        .drop  (drop)
    );

endmodule
